tick_sequencer: RTL

// Parametrised successor to the fixed 100-cycle tick delay that derives the master sample tick from the ADC data-ready tick.

---
 rtl/tick_sequencer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/tick_sequencer.sv
// Turns one input tick into NUM_PHASES delayed one-cycle phase ticks, with watchdog, overrun flag and sequence counter.
// Optional build macro TICK_SEQ_FREERUN_EN: a watchdog timeout starts a synthetic sequence.
module tick_sequencer #(
    parameter int NUM_PHASES     = 4,
    parameter int CNT_WIDTH      = 9,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TS_WIDTH       = 32
) (
    input  logic                            clk_i,
    input  logic                            reset_ni,
    input  logic                            enable_i,
    input  logic                            tick_i,
    input  logic [NUM_PHASES*CNT_WIDTH-1:0] delay_i,
    input  logic                            clear_i,
    output logic [NUM_PHASES-1:0]           tick_o,
    output logic                            busy_o,
    output logic [TS_WIDTH-1:0]             count_o,
    output logic                            missed_o,
    output logic                            overrun_o
);

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                                 state_q, state_d;
    logic [CNT_WIDTH-1:0]                   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]                   max_q, max_d;
    logic [NUM_PHASES-1:0][CNT_WIDTH-1:0]   dly_q, dly_d;
    logic [NUM_PHASES-1:0]                  tick_q, tick_d;
    logic [TS_WIDTH-1:0]                    count_q, count_d;
    logic [WD_W-1:0]                        wd_q, wd_d;
    logic                                   missed_q, missed_d;
    logic                                   ovr_q, ovr_d;
    logic                                   start;
    logic                                   last;
    logic [CNT_WIDTH-1:0]                   field;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            max_q    <= '0;
            dly_q    <= '0;
            tick_q   <= '0;
            count_q  <= '0;
            wd_q     <= '0;
            missed_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            max_q    <= max_d;
            dly_q    <= dly_d;
            tick_q   <= tick_d;
            count_q  <= count_d;
            wd_q     <= wd_d;
            missed_q <= missed_d;
            ovr_q    <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        max_d   = max_q;
        dly_d   = dly_q;
        tick_d  = '0;
        count_d = count_q;
        ovr_d   = ovr_q;
        field   = '0;
        last    = (state_q == RUN) && (cnt_q == max_q);
`ifdef TICK_SEQ_FREERUN_EN
        start   = enable_i && (tick_i || missed_q);
`else
        start   = enable_i && tick_i;
`endif

        // missed_q is registered from wd_d so it is high in the same cycle wd_q hits the limit
        if (!enable_i || tick_i || (wd_q == WD_W'(TIMEOUT_CYCLES - 1)))
            wd_d = '0;
        else
            wd_d = wd_q + 1'b1;
        missed_d = (wd_d == WD_W'(TIMEOUT_CYCLES - 1));

        if (!enable_i) begin
            state_d = IDLE;
        end else if (start) begin
            state_d = RUN;
            cnt_d   = CNT_WIDTH'(1);
            max_d   = '0;
            for (int k = 0; k < NUM_PHASES; k++) begin
                field = delay_i[k*CNT_WIDTH +: CNT_WIDTH];
                if (field == '0)
                    field = CNT_WIDTH'(1);
                dly_d[k]  = field;
                tick_d[k] = (field == CNT_WIDTH'(1));
                if (field > max_d)
                    max_d = field;
            end
            // a tick landing on the final phase cycle still completes the old sequence
            if (last)
                count_d = count_q + 1'b1;
        end else if (state_q == RUN) begin
            if (last) begin
                state_d = IDLE;
                count_d = count_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
                for (int k = 0; k < NUM_PHASES; k++)
                    tick_d[k] = (cnt_d == dly_q[k]);
            end
        end

        if (start && (state_q == RUN))
            ovr_d = 1'b1;
        else if (clear_i)
            ovr_d = 1'b0;
    end

    assign tick_o    = tick_q;
    assign busy_o    = (state_q == RUN);
    assign count_o   = count_q;
    assign missed_o  = missed_q;
    assign overrun_o = ovr_q;

endmodule
